sprite_tile_dispatcher: RTL
===========================

Name: sprite_tile_dispatcher

Overview:
Sequences one 16x2 pixel tile through the stream-processor array. On start it clears the array, paints the background at z=0, then walks the sprite table in index order. For each sprite that overlaps the tile it fetches the two relevant texture rows and broadcasts a single dispatch beat (texture, start_x, z, ena) to all 32 processors. It sits between the frame scanner (start/done) and the sprite-table RAM, texture RAM and processor array.

Parameters:
SPR_AW, 6, sprite table address width (max 2^SPR_AW sprites)
TEX_AW, 12, texture memory word address width (one word = one 16-pixel row)
TRANSPARENT, 8'hFF, colour code used to fill pixels outside a sprite

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
i_start  input  1  start pulse for one tile; ignored while busy
i_tile_x  input  4  tile column (pixel x = i_tile_x*16); latched on start
i_tile_y  input  7  tile row pair (pixel rows 2*i_tile_y, +1); latched on start
i_sprite_count  input  SPR_AW+1  number of valid table entries; latched on start
i_bg_color  input  8  background colour; latched on start
o_busy  output  1  high from the cycle after accepted start until done
o_done  output  1  one-cycle pulse when the tile is complete
o_spr_addr  output  SPR_AW  sprite table read address (1-cycle read latency)
i_spr_data  input  40  {x[39:32], y[31:24], z[23:16], height_m1[15:12], tex_base[11:0]}
o_tex_req  output  1  texture read request, held until i_tex_valid
o_tex_addr  output  TEX_AW  tex_base + sprite row
i_tex_data  input  128  texture row, pixel c at bits [c*8+:8]
i_tex_valid  input  1  texture data valid (any latency >= 1)
o_array_reset_n  output  1  active-low clear to the processor array
o_ena  output  1  dispatch strobe to the array
o_texture_data  output  256  row0 in [127:0], row1 in [255:128]
o_start_x  output  4  first covered column within the tile
o_position_z  output  8  sprite depth

Behaviour:
- Reset: state IDLE. o_busy=0, o_done=0, o_tex_req=0, o_ena=0, o_array_reset_n=1, all data outputs 0.
- FSM: IDLE -> CLEAR -> BG -> SPR_RD -> SPR_EVAL -> (TEX0 -> TEX1 -> DISPATCH) | skip -> SPR_RD/DONE -> IDLE.
- IDLE: when i_start=1, latch the inputs, clear the sprite index, and go to CLEAR.
- CLEAR: drive o_array_reset_n=0 for exactly 1 cycle.
- BG: 1 cycle with o_ena=1, z=0, start_x=0 and all 32 pixels = bg colour. z=0 bypasses transparency, so the background is always written.
- SPR_RD: if index == count, go to DONE. Otherwise drive o_spr_addr=index and move to SPR_EVAL next cycle, where data is valid.
- SPR_EVAL: skip the sprite (index+1, back to SPR_RD) when any of these holds:
  - z==0 (reserved for the background);
  - neither tile row is covered;
  - no x overlap.
- Row coverage: row r (Yr = 2*tile_y + r) is covered iff 0 <= Yr - y <= height_m1. Compute in 9-bit signed so there is no wrap.
- X overlap: x[7:4]==tile_x gives start_x=x[3:0] with no shift. Otherwise no overlap (see Optional Feature).
- TEX0/TEX1: for a covered row, hold o_tex_req=1 with o_tex_addr = tex_base + (Yr - y) until i_tex_valid, then capture. For an uncovered row, skip the fetch (0 cycles) and fill that row with TRANSPARENT.
- DISPATCH: o_ena=1 for exactly 1 cycle with the captured data, start_x and z. Then index+1 and go to SPR_RD.
- Ordering: sprites dispatch in ascending index order. At equal z the later index wins, because the array compares with <=.
- o_ena is 0 in every state except BG and DISPATCH. Data outputs are held otherwise.
- DONE: o_done=1 for 1 cycle, o_busy drops, return to IDLE. A start in the same cycle as done is ignored.
- count==0: CLEAR, BG, DONE (4 cycles from start to done).
- Reset mid-operation: returns to IDLE immediately. An outstanding texture response is ignored (i_tex_valid is ignored outside TEX states).
- Address arithmetic: tex_base + row truncates to TEX_AW (wraps).

Optional Feature:
Macro SPRITE_DISPATCH_LEFT_CLIP_EN.
- Defined: a sprite with x[7:4]==tile_x-1 and x[3:0]!=0 also overlaps, with k = 16 - x[3:0]. Each fetched row is shifted so pixel c takes pixel c+k; vacated columns are filled with TRANSPARENT. start_x=0. Not applied when tile_x==0 (no wrap).
- Undefined: such sprites are skipped and no shifter is built.

Test Plan:
- count=0, bg=0x12 -> array clear 1 cycle, one ena beat with z=0 and all 32 pixels 0x12; done 4 cycles after start.
- One sprite x=0x35, y=4, z=7, h_m1=1, tile_x=3, tile_y=2, tex_valid after 3 cycles -> tex addrs base+0 and base+1, start_x=5, z=7, one ena beat.
- Sprite y=5, h_m1=0, tile_y=2 -> only row1 fetched (addr base+0); row0 all 0xFF; single request.
- Sprites A (z=5) and B (z=5, higher index) plus C (z=0) -> A dispatched, then B; C never dispatched and never fetched.
- x=0x2C, tile_x=3: with the macro -> dispatched with start_x=0, cols 0..11 = texture cols 4..15, cols 12..15 = 0xFF; without the macro -> skipped.
- reset_n low while o_tex_req=1 -> next cycle o_busy=0, o_tex_req=0; a late i_tex_valid has no effect; a new start runs normally.

Source files
------------

// File: rtl/sprite_tile_dispatcher.sv
// Sequences one 16x2 tile: clears the stream-processor array, paints the background,
// then fetches and dispatches every overlapping sprite. Optional left clip: SPRITE_DISPATCH_LEFT_CLIP_EN.
module sprite_tile_dispatcher #(
    parameter int         SPR_AW      = 6,
    parameter int         TEX_AW      = 12,
    parameter logic [7:0] TRANSPARENT = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [3:0]        i_tile_x,
    input  logic [6:0]        i_tile_y,
    input  logic [SPR_AW:0]   i_sprite_count,
    input  logic [7:0]        i_bg_color,
    output logic              o_busy,
    output logic              o_done,
    output logic [SPR_AW-1:0] o_spr_addr,
    input  logic [39:0]       i_spr_data,
    output logic              o_tex_req,
    output logic [TEX_AW-1:0] o_tex_addr,
    input  logic [127:0]      i_tex_data,
    input  logic              i_tex_valid,
    output logic              o_array_reset_n,
    output logic              o_ena,
    output logic [255:0]      o_texture_data,
    output logic [3:0]        o_start_x,
    output logic [7:0]        o_position_z
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_BG, S_SPR_RD, S_SPR_EVAL, S_TEX0, S_TEX1, S_DISPATCH, S_DONE
    } state_t;

    localparam logic [127:0]    CLEAR_ROW = {16{TRANSPARENT}};
    localparam logic [SPR_AW:0] IDX_ONE   = {{SPR_AW{1'b0}}, 1'b1};

    state_t              state_r, state_s;
    logic [SPR_AW:0]     idx_r, idx_s, count_r;
    logic [3:0]          tile_x_r;
    logic [6:0]          tile_y_r;
    logic [7:0]          bg_r;
    logic [7:0]          spr_z_r;
    logic [3:0]          spr_sx_r;
    logic                cov1_r;
    logic [TEX_AW-1:0]   addr0_r, addr1_r, tex_addr_s;
    logic [127:0]        row0_r, row1_r, row0_s, row1_s, row_in_s;

    logic [7:0]          spr_x_s, spr_y_s, spr_z_s;
    logic [3:0]          spr_h_s;
    logic [11:0]         spr_base_s;
    logic [8:0]          d0_s, d1_s;
    logic                cov0_s, cov1_s, direct_s, clip_s, hit_s;
    logic [TEX_AW-1:0]   addr0_eval_s, addr1_eval_s;

    assign spr_x_s    = i_spr_data[39:32];
    assign spr_y_s    = i_spr_data[31:24];
    assign spr_z_s    = i_spr_data[23:16];
    assign spr_h_s    = i_spr_data[15:12];
    assign spr_base_s = i_spr_data[11:0];

    // Row distances are 9-bit signed so a sprite starting below the row never wraps into coverage.
    assign d0_s   = {1'b0, tile_y_r, 1'b0} - {1'b0, spr_y_s};
    assign d1_s   = {1'b0, tile_y_r, 1'b1} - {1'b0, spr_y_s};
    assign cov0_s = ~d0_s[8] & (d0_s[7:0] <= {4'h0, spr_h_s});
    assign cov1_s = ~d1_s[8] & (d1_s[7:0] <= {4'h0, spr_h_s});
    assign direct_s = (spr_x_s[7:4] == tile_x_r);
    assign hit_s  = (spr_z_s != 8'h00) & (cov0_s | cov1_s) & (direct_s | clip_s);

    assign addr0_eval_s = TEX_AW'(spr_base_s) + TEX_AW'(d0_s[3:0]);
    assign addr1_eval_s = TEX_AW'(spr_base_s) + TEX_AW'(d1_s[3:0]);

`ifdef SPRITE_DISPATCH_LEFT_CLIP_EN
    logic [3:0] spr_shift_r;

    function automatic logic [127:0] shift_row(input logic [127:0] d, input logic [3:0] k);
        logic [127:0] r;
        r = CLEAR_ROW;
        for (int c = 0; c < 16; c++) begin
            if (c + int'(k) < 16) begin
                r[c*8 +: 8] = d[(c + int'(k))*8 +: 8];
            end else begin
                r[c*8 +: 8] = TRANSPARENT;
            end
        end
        return r;
    endfunction

    assign clip_s   = (tile_x_r != 4'h0) & (spr_x_s[7:4] == (tile_x_r - 4'h1)) & (spr_x_s[3:0] != 4'h0);
    assign row_in_s = shift_row(i_tex_data, spr_shift_r);

    // Shift amount for a left-clipped sprite is 16 - x[3:0], zero for an aligned hit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spr_shift_r <= 4'h0;
        end else if (state_r == S_SPR_EVAL) begin
            spr_shift_r <= direct_s ? 4'h0 : (4'h0 - spr_x_s[3:0]);
        end
    end
`else
    assign clip_s   = 1'b0;
    assign row_in_s = i_tex_data;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, sprite index and captured texture rows.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        row0_s  = row0_r;
        row1_s  = row1_r;
        case (state_r)
            S_IDLE: begin
                if (i_start) begin
                    state_s = S_CLEAR;
                    idx_s   = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLEAR: state_s = S_BG;
            S_BG:    state_s = S_SPR_RD;
            S_SPR_RD: begin
                if (idx_r == count_r) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_SPR_EVAL;
                end
            end
            S_SPR_EVAL: begin
                row0_s = CLEAR_ROW;
                row1_s = CLEAR_ROW;
                if (!hit_s) begin
                    state_s = S_SPR_RD;
                    idx_s   = idx_r + IDX_ONE;
                end else if (cov0_s) begin
                    state_s = S_TEX0;
                end else begin
                    state_s = S_TEX1;
                end
            end
            S_TEX0: begin
                if (i_tex_valid) begin
                    row0_s  = row_in_s;
                    state_s = cov1_r ? S_TEX1 : S_DISPATCH;
                end else begin
                    state_s = S_TEX0;
                end
            end
            S_TEX1: begin
                if (i_tex_valid) begin
                    row1_s  = row_in_s;
                    state_s = S_DISPATCH;
                end else begin
                    state_s = S_TEX1;
                end
            end
            S_DISPATCH: begin
                state_s = S_SPR_RD;
                idx_s   = idx_r + IDX_ONE;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Texture address for the fetch being entered; from EVAL the sprite word is still on the bus.
    always_comb begin
        tex_addr_s = o_tex_addr;
        if (state_s == S_TEX0) begin
            tex_addr_s = (state_r == S_SPR_EVAL) ? addr0_eval_s : addr0_r;
        end else if (state_s == S_TEX1) begin
            tex_addr_s = (state_r == S_SPR_EVAL) ? addr1_eval_s : addr1_r;
        end else begin
            tex_addr_s = o_tex_addr;
        end
    end

    // Datapath registers and registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_r           <= '0;
            count_r         <= '0;
            tile_x_r        <= 4'h0;
            tile_y_r        <= 7'h00;
            bg_r            <= 8'h00;
            spr_z_r         <= 8'h00;
            spr_sx_r        <= 4'h0;
            cov1_r          <= 1'b0;
            addr0_r         <= '0;
            addr1_r         <= '0;
            row0_r          <= '0;
            row1_r          <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_spr_addr      <= '0;
            o_tex_req       <= 1'b0;
            o_tex_addr      <= '0;
            o_array_reset_n <= 1'b1;
            o_ena           <= 1'b0;
            o_texture_data  <= '0;
            o_start_x       <= 4'h0;
            o_position_z    <= 8'h00;
        end else begin
            idx_r  <= idx_s;
            row0_r <= row0_s;
            row1_r <= row1_s;
            if (state_r == S_IDLE && i_start) begin
                tile_x_r <= i_tile_x;
                tile_y_r <= i_tile_y;
                count_r  <= i_sprite_count;
                bg_r     <= i_bg_color;
            end
            if (state_r == S_SPR_EVAL) begin
                spr_z_r  <= spr_z_s;
                spr_sx_r <= direct_s ? spr_x_s[3:0] : 4'h0;
                cov1_r   <= cov1_s;
                addr0_r  <= addr0_eval_s;
                addr1_r  <= addr1_eval_s;
            end
            o_busy          <= (state_s != S_IDLE) && (state_s != S_DONE);
            o_done          <= (state_s == S_DONE);
            o_array_reset_n <= (state_s != S_CLEAR);
            o_ena           <= (state_s == S_BG) || (state_s == S_DISPATCH);
            o_tex_req       <= (state_s == S_TEX0) || (state_s == S_TEX1);
            o_tex_addr      <= tex_addr_s;
            if (state_s == S_SPR_RD) begin
                o_spr_addr <= idx_s[SPR_AW-1:0];
            end
            if (state_s == S_BG) begin
                o_texture_data <= {32{bg_r}};
                o_start_x      <= 4'h0;
                o_position_z   <= 8'h00;
            end else if (state_s == S_DISPATCH) begin
                o_texture_data <= {row1_s, row0_s};
                o_start_x      <= spr_sx_r;
                o_position_z   <= spr_z_r;
            end
        end
    end

endmodule
